// File: rtl/conv55_pkg.sv
// Shared constants for the 5x5 convolution window path.
package conv55_pkg;
  localparam int unsigned DATA_W = 6;
  localparam int unsigned K      = 5;
  localparam int unsigned LINES  = K - 1;
  localparam int unsigned WIN_W  = K * K * DATA_W;

  function automatic int unsigned win_width(input int unsigned dw);
    return K * K * dw;
  endfunction
endpackage

// File: rtl/conv55_line_buf.sv
// One image line of pixel storage: read-before-write at a single address.
module conv55_line_buf #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned DATA_W = 6
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   addr,
  input  logic [DATA_W-1:0]          wdata,
  output logic [DATA_W-1:0]          rdata
);
  logic [DATA_W-1:0] mem [DEPTH];

  // Read is combinational so the old value reaches the window in the same
  // cycle the new pixel overwrites it; contents are intentionally not reset.
  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end
endmodule

// File: rtl/conv55_window_gen.sv
// Raster-scan 5x5 window generator: four cascaded line buffers feed a shift window.
module conv55_window_gen
  import conv55_pkg::*;
#(
  parameter int unsigned IMG_W  = 32,
  parameter int unsigned IMG_H  = 32,
  parameter int unsigned DATA_W = conv55_pkg::DATA_W
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            sof,
  input  logic                            in_valid,
  input  logic [DATA_W-1:0]               in_data,
  output logic                            out_valid,
  output logic [win_width(DATA_W)-1:0]    out_window,
  output logic [$clog2(IMG_H)-1:0]        out_row,
  output logic [$clog2(IMG_W)-1:0]        out_col
);
  localparam int unsigned CW = $clog2(IMG_W);
  localparam int unsigned RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0] col, eff_col;
  logic [RW-1:0] row, eff_row;
  logic          restart, valid_pos;

  logic [DATA_W-1:0] lb_rd [LINES];
  logic [DATA_W-1:0] lb_wd [LINES];

  logic [K*K-1:0][DATA_W-1:0] win_q, win_d;

  assign restart   = in_valid & sof;
  assign eff_col   = restart ? '0 : col;
  assign eff_row   = restart ? '0 : row;
  assign valid_pos = (eff_row >= RW'(K - 1)) && (eff_col >= CW'(K - 1));

  // Line 0 holds the previous row; each accepted pixel pushes its column up one line.
  for (genvar i = 0; i < LINES; i++) begin : g_line
    if (i == 0) begin : g_head
      assign lb_wd[i] = in_data;
    end else begin : g_tail
      assign lb_wd[i] = lb_rd[i-1];
    end
    conv55_line_buf #(
      .DEPTH  (IMG_W),
      .DATA_W (DATA_W)
    ) u_line (
      .clk   (clk),
      .we    (in_valid),
      .addr  (eff_col),
      .wdata (lb_wd[i]),
      .rdata (lb_rd[i])
    );
  end

  always_comb begin
    win_d = win_q;
    for (int unsigned r = 0; r < K; r++) begin
      for (int unsigned c = 0; c < K - 1; c++) begin
        win_d[K*r+c] = win_q[K*r+c+1];
      end
    end
    for (int unsigned r = 0; r < K - 1; r++) begin
      win_d[K*r+K-1] = lb_rd[LINES-1-r];
    end
    win_d[K*K-1] = in_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col        <= '0;
      row        <= '0;
      win_q      <= '0;
      out_valid  <= 1'b0;
      out_window <= '0;
      out_row    <= '0;
      out_col    <= '0;
    end else begin
      out_valid <= 1'b0;
      if (in_valid) begin
        win_q <= win_d;
        if (eff_col == COL_LAST) begin
          col <= '0;
          row <= (eff_row == ROW_LAST) ? '0 : eff_row + RW'(1);
        end else begin
          col <= eff_col + CW'(1);
          row <= eff_row;
        end
        if (valid_pos) begin
          out_valid  <= 1'b1;
          out_window <= win_d;
          out_row    <= eff_row - RW'(2);
          out_col    <= eff_col - CW'(2);
        end
      end
    end
  end
endmodule

// File: tb/tb_conv55_window_gen.sv
// Directed bench for conv55_window_gen on an 8x8 image.
module tb_conv55_window_gen;
  localparam int W  = 8;
  localparam int H  = 8;
  localparam int DW = 6;
  localparam int WB = 25 * DW;

  logic          clk = 1'b0;
  logic          rst, sof, in_valid;
  logic [DW-1:0] in_data;
  logic          out_valid;
  logic [WB-1:0] out_window;
  logic [2:0]    out_row, out_col;

  int errors = 0;
  int checks = 0;
  int mr, mc, wins;
  logic [DW-1:0] img [H][W];
  logic [WB-1:0] exp_win;
  int            exp_row, exp_col;

  always #5 clk = ~clk;

  conv55_window_gen #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .sof        (sof),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .out_valid  (out_valid),
    .out_window (out_window),
    .out_row    (out_row),
    .out_col    (out_col)
  );

  task automatic chk(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic chki(input string tag, input int obs, input int expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_held();
    chk ("held_window", out_window, exp_win);
    chki("held_row", int'(out_row), exp_row);
    chki("held_col", int'(out_col), exp_col);
  endtask

  task automatic idle();
    sof = 1'b0; in_valid = 1'b0;
    @(posedge clk); #1;
    chki("idle_valid", int'(out_valid), 0);
    check_held();
  endtask

  task automatic push(input int d, input bit s);
    if (s) begin mr = 0; mc = 0; end
    img[mr][mc] = DW'(d);
    sof = s; in_valid = 1'b1; in_data = DW'(d);
    @(posedge clk); #1;
    sof = 1'b0; in_valid = 1'b0;
    if (mr >= 4 && mc >= 4) begin
      for (int i = 0; i < 5; i++)
        for (int j = 0; j < 5; j++)
          exp_win[DW*(5*i+j) +: DW] = img[mr-4+i][mc-4+j];
      exp_row = mr - 2;
      exp_col = mc - 2;
      wins++;
      chki("win_valid", int'(out_valid), 1);
    end else begin
      chki("no_valid", int'(out_valid), 0);
    end
    check_held();
    if (mc == W - 1) begin
      mc = 0;
      mr = (mr == H - 1) ? 0 : mr + 1;
    end else begin
      mc++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1; sof = 1'b0; in_valid = 1'b0; in_data = '0;
    #1;
    chki("rst_valid", int'(out_valid), 0);
    repeat (2) begin
      @(posedge clk); #1;
      chki("rst_valid_hold", int'(out_valid), 0);
    end
    rst = 1'b0;
    mr = 0; mc = 0;
    exp_win = '0; exp_row = 0; exp_col = 0;
    check_held();
  endtask

  initial begin
    do_reset();

    // Full frame at one pixel per cycle, with row-boundary anchors.
    wins = 0;
    for (int idx = 0; idx < 64; idx++) begin
      push(idx, idx == 0);
      if (idx == 35) chki("pre_first_valid", int'(out_valid), 0);
      if (idx == 36) begin
        chki("first_elem0", int'(out_window[DW-1:0]), 0);
        chki("first_elem24", int'(out_window[WB-1 -: DW]), 36);
        chki("first_row", int'(out_row), 2);
        chki("first_col", int'(out_col), 2);
      end
      if (idx >= 40 && idx <= 43) chki("row_gap", int'(out_valid), 0);
      if (idx == 44) chki("row4_elem0", int'(out_window[DW-1:0]), 8);
    end
    chki("frame_wins", wins, 16);

    // Same frame with random gaps.
    wins = 0;
    for (int idx = 0; idx < 64; idx++) begin
      if ($urandom_range(0, 1) == 1) idle();
      push(idx, idx == 0);
    end
    idle();
    chki("gap_frame_wins", wins, 16);

    // Reset mid-frame, then a frame without sof.
    for (int idx = 0; idx < 20; idx++) push(idx, idx == 0);
    do_reset();
    wins = 0;
    for (int idx = 0; idx < 64; idx++) push(idx, 1'b0);
    chki("post_rst_wins", wins, 16);

    // sof reasserted at pixel 30 with distinct new-frame data.
    for (int idx = 0; idx < 30; idx++) push(idx, idx == 0);
    wins = 0;
    for (int idx = 0; idx < 64; idx++) begin
      push((idx + 17) % 64, idx == 0);
      if (idx == 36) chki("resof_elem0", int'(out_window[DW-1:0]), 17);
    end
    chki("resof_wins", wins, 16);

    // Two back-to-back frames.
    wins = 0;
    for (int f = 0; f < 2; f++) begin
      for (int idx = 0; idx < 64; idx++) begin
        push(idx, idx == 0);
        if (f == 1 && idx == 36) chki("f2_elem0", int'(out_window[DW-1:0]), 0);
      end
    end
    chki("b2b_wins", wins, 32);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
